// File: rtl/mcu_top.sv
// rtl/mcu_top.sv - single-cycle RV32I-subset microcontroller with internal ROM, data RAM and 4-bit GPO
// ROM_IMAGE selects the built-in program: 0 = GPO counter, 1 = ISA self-check, 2 = GPO readback.
module mcu_top #(
  parameter int          IMEM_WORDS = 64,
  parameter int          DMEM_WORDS = 64,
  parameter logic [31:0] GPO_ADDR   = 32'h1000_0000,
  parameter int          ROM_IMAGE  = 0
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] gpo
);

  localparam int          IAW = $clog2(IMEM_WORDS);
  localparam int          DAW = $clog2(DMEM_WORDS);
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  function automatic logic [31:0] rom_word(input int idx);
    logic [31:0] w;
    w = NOP;
    if (ROM_IMAGE == 1) begin
      case (idx)
        0:  w = 32'h100000B7;  1:  w = 32'h00700113;  2:  w = 32'hFFD00193;
        3:  w = 32'h00310233;  4:  w = 32'h402182B3;  5:  w = 32'h0021A333;
        6:  w = 32'h0021B3B3;  7:  w = 32'h00211433;  8:  w = 32'h4062D4B3;
        9:  w = 32'h0062D533;  10: w = 32'h0040A023;  11: w = 32'h0092C5B3;
        12: w = 32'h00A585B3;  13: w = 32'h0085E5B3;  14: w = 32'h3F05F613;
        15: w = 32'h00564613;  16: w = 32'h04066613;  17: w = 32'hFFE1A693;
        18: w = 32'h00C0A023;  19: w = 32'h00310463;  20: w = 32'h00100713;
        21: w = 32'h00668463;  22: w = 32'h10070713;  23: w = 32'h0021C463;
        24: w = 32'h20070713;  25: w = 32'h0021D463;  26: w = 32'h00270713;
        27: w = 32'h00071463;  28: w = 32'h40070713;  29: w = 32'h00E0A023;
        30: w = 32'h008007EF;  31: w = 32'h40070713;  32: w = 32'h00C78867;
        33: w = 32'h40070713;  34: w = 32'h40F808B3;  35: w = 32'h0110A023;
        36: w = 32'h04502023;  37: w = 32'h04002903;  38: w = 32'h00000997;
        39: w = 32'h01390A33;  40: w = 32'h00CA4A33;  41: w = 32'h00EA0A33;
        42: w = 32'h011A0A33;  43: w = 32'h00DA0A33;  44: w = 32'h007A0A33;
        45: w = 32'h003A0A13;  46: w = 32'h0140A023;  47: w = 32'h00500013;
        48: w = 32'h0000A023;  49: w = 32'h0000006F;
        default: ;
      endcase
    end else if (ROM_IMAGE == 2) begin
      case (idx)
        0: w = 32'h100000B7;  1: w = 32'h01F00113;  2: w = 32'h0020A023;
        3: w = 32'h0000A183;  4: w = 32'hFFA18213;  5: w = 32'h0040A023;
        6: w = 32'h0000006F;
        default: ;
      endcase
    end else begin
      case (idx)
        0: w = 32'h100000B7;  1: w = 32'h00000113;  2: w = 32'h0020A023;
        3: w = 32'h00110113;  4: w = 32'hFF9FF06F;
        default: ;
      endcase
    end
    return w;
  endfunction

  logic [31:0] pc_q, pc_d;
  logic [3:0]  gpo_q, gpo_d;
  logic [31:0] rf_q [32];
  logic [31:0] dmem_q [DMEM_WORDS];

  logic [31:0] instr;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, alu_b, alu_res, addr_sum, load_data, pc_plus4;
  logic        alu_alt, r_ok, i_ok, br_taken, is_gpo, rd_we, dmem_we;
  logic [31:0] rd_wdata;
  logic [DAW-1:0] dmem_idx;
  logic        unused_addr0;

  assign instr  = rom_word(int'(pc_q[IAW+1:2]));
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

  // Only the listed funct3/funct7 combinations write back; anything else retires as a NOP.
  assign r_ok = (funct7 == 7'b0000000) ||
                (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
  assign i_ok = (funct3 == 3'b000) || (funct3 == 3'b010) || (funct3 == 3'b100) ||
                (funct3 == 3'b110) || (funct3 == 3'b111);

  assign alu_alt = (opcode == OPC_OP) && instr[30];
  assign alu_b   = (opcode == OPC_OP) ? rs2_val : imm_i;

  always_comb begin
    alu_res = 32'd0;
    case (funct3)
      3'b000:  alu_res = alu_alt ? (rs1_val - alu_b) : (rs1_val + alu_b);
      3'b001:  alu_res = rs1_val << alu_b[4:0];
      3'b010:  alu_res = {31'b0, $signed(rs1_val) < $signed(alu_b)};
      3'b011:  alu_res = {31'b0, rs1_val < alu_b};
      3'b100:  alu_res = rs1_val ^ alu_b;
      3'b101:  alu_res = alu_alt ? $unsigned($signed(rs1_val) >>> alu_b[4:0])
                                 : (rs1_val >> alu_b[4:0]);
      3'b110:  alu_res = rs1_val | alu_b;
      default: alu_res = rs1_val & alu_b;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      default: br_taken = 1'b0;
    endcase
  end

  // Shared adder: load/store effective address and JALR target.
  assign addr_sum     = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
  assign is_gpo       = (addr_sum[31:2] == GPO_ADDR[31:2]);
  assign dmem_idx     = addr_sum[DAW+1:2];
  assign load_data    = is_gpo ? {28'b0, gpo_q} : dmem_q[dmem_idx];
  assign pc_plus4     = pc_q + 32'd4;
  assign unused_addr0 = addr_sum[0];

  always_comb begin
    pc_d     = pc_plus4;
    gpo_d    = gpo_q;
    rd_we    = 1'b0;
    rd_wdata = alu_res;
    dmem_we  = 1'b0;
    case (opcode)
      OPC_OP:    rd_we = r_ok;
      OPC_OPIMM: rd_we = i_ok;
      OPC_LUI: begin
        rd_we    = 1'b1;
        rd_wdata = imm_u;
      end
      OPC_AUIPC: begin
        rd_we    = 1'b1;
        rd_wdata = pc_q + imm_u;
      end
      OPC_JAL: begin
        rd_we    = 1'b1;
        rd_wdata = pc_plus4;
        pc_d     = pc_q + imm_j;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          rd_we    = 1'b1;
          rd_wdata = pc_plus4;
          pc_d     = {addr_sum[31:1], 1'b0};
        end
      end
      OPC_BRANCH: begin
        if (br_taken) pc_d = pc_q + imm_b;
      end
      OPC_LOAD: begin
        if (funct3 == 3'b010) begin
          rd_we    = 1'b1;
          rd_wdata = load_data;
        end
      end
      OPC_STORE: begin
        if (funct3 == 3'b010) begin
          if (is_gpo) gpo_d = rs2_val[3:0];
          else        dmem_we = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= 32'd0;
      gpo_q <= 4'd0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else begin
      pc_q  <= pc_d;
      gpo_q <= gpo_d;
      if (rd_we && rd != 5'd0) rf_q[rd] <= rd_wdata;
    end
  end

  // Data RAM has no reset; its contents after reset are undefined by design.
  always_ff @(posedge clk) begin
    if (dmem_we) dmem_q[dmem_idx] <= rs2_val;
  end

  assign gpo = gpo_q;

endmodule

// File: tb/tb_mcu_top.sv
// tb/tb_mcu_top.sv - directed self-checking bench for mcu_top (counter, async reset, ISA and readback images)
module tb_mcu_top;

  logic       clk = 1'b0;
  logic       rst_main;
  logic       rst_isa;
  logic [3:0] gpo_main;
  logic [3:0] gpo_isa;
  logic [3:0] gpo_rb;
  int         n_cmp = 0;
  int         n_mis = 0;

  always #5 clk = ~clk;

  mcu_top dut (
    .clk   (clk),
    .reset (rst_main),
    .gpo   (gpo_main)
  );

  mcu_top #(.ROM_IMAGE(1)) dut_isa (
    .clk   (clk),
    .reset (rst_isa),
    .gpo   (gpo_isa)
  );

  mcu_top #(.ROM_IMAGE(2)) dut_rb (
    .clk   (clk),
    .reset (rst_isa),
    .gpo   (gpo_rb)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counter program: value n appears after edge 3+3n, wrapping mod 16.
  function automatic logic [3:0] cnt_exp(input int e);
    if (e < 3) return 4'd0;
    return 4'((e - 3) / 3);
  endfunction

  // ISA image GPO writes: 4 @11, 5 @19, 3 @27, 8 @31, checksum A @42, x0 store 0 @44.
  function automatic logic [3:0] isa_exp(input int e);
    if (e >= 44) return 4'h0;
    if (e >= 42) return 4'hA;
    if (e >= 31) return 4'h8;
    if (e >= 27) return 4'h3;
    if (e >= 19) return 4'h5;
    if (e >= 11) return 4'h4;
    return 4'h0;
  endfunction

  function automatic logic [3:0] rb_exp(input int e);
    if (e >= 6) return 4'h9;
    if (e >= 3) return 4'hF;
    return 4'h0;
  endfunction

  initial begin
    rst_main = 1'b0;
    rst_isa  = 1'b0;

    repeat (2) begin
      tick();
      check_eq("rst_gpo", {28'b0, gpo_main}, 32'h0);
      check_eq("rst_pc", dut.pc_q, 32'h0);
    end

    @(negedge clk);
    rst_main = 1'b1;
    for (int e = 1; e <= 60; e++) begin
      tick();
      check_eq($sformatf("cnt_e%0d", e), {28'b0, gpo_main}, {28'b0, cnt_exp(e)});
    end

    #2 rst_main = 1'b0;
    #1;
    check_eq("async_clr_gpo", {28'b0, gpo_main}, 32'h0);
    check_eq("async_clr_pc", dut.pc_q, 32'h0);

    @(negedge clk);
    rst_main = 1'b1;
    for (int e = 1; e <= 20; e++) tick();
    check_eq("mid_e20", {28'b0, gpo_main}, 32'h5);
    #2 rst_main = 1'b0;
    #1;
    check_eq("mid_async_gpo", {28'b0, gpo_main}, 32'h0);
    check_eq("mid_async_pc", dut.pc_q, 32'h0);
    tick();
    check_eq("mid_held_gpo", {28'b0, gpo_main}, 32'h0);
    @(negedge clk);
    rst_main = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      check_eq($sformatf("restart_e%0d", e), {28'b0, gpo_main}, {28'b0, cnt_exp(e)});
    end

    @(negedge clk);
    rst_isa = 1'b1;
    for (int e = 1; e <= 50; e++) begin
      tick();
      check_eq($sformatf("isa_e%0d", e), {28'b0, gpo_isa}, {28'b0, isa_exp(e)});
      check_eq($sformatf("rb_e%0d", e), {28'b0, gpo_rb}, {28'b0, rb_exp(e)});
      if (e == 4) check_eq("rb_lw_x3", dut_rb.rf_q[3], 32'h0000_000F);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
